// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier. One Booth step per clock over N+1 steps,
// operands extended to N+1 bits so unsigned and two's-complement share one datapath.
module booth_multiplier #(
  parameter int unsigned N = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [N-1:0]     M,
  input  logic [N-1:0]     Q,
  output logic [2*N-1:0]   product,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W    = N + 1;
  localparam int unsigned CntW = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    qx_q, qx_d;
  logic            qm1_q, qm1_d;
  logic [W-1:0]    mx_q, mx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]  product_q, product_d;
  logic            done_q, done_d;

  logic [W-1:0]    a_sum;
  logic [W-1:0]    a_shr;
  logic [W-1:0]    qx_shr;
  logic [2*W-1:0]  full_shr;
  logic [W-1:0]    m_ext;
  logic [W-1:0]    q_ext;

  // Booth add/subtract followed by arithmetic right shift of {A, Qx, q-1}
  always_comb begin
    m_ext = signed_mode ? {M[N-1], M} : {1'b0, M};
    q_ext = signed_mode ? {Q[N-1], Q} : {1'b0, Q};
    unique case ({qx_q[0], qm1_q})
      2'b10:   a_sum = a_q - mx_q;
      2'b01:   a_sum = a_q + mx_q;
      default: a_sum = a_q;
    endcase
    a_shr    = {a_sum[W-1], a_sum[W-1:1]};
    qx_shr   = {a_sum[0], qx_q[W-1:1]};
    full_shr = {a_shr, qx_shr};
  end

  // Next-state logic: capture on start from IDLE/DONE, step while RUN
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    qx_d      = qx_q;
    qm1_d     = qm1_q;
    mx_d      = mx_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = '0;
          qx_d    = q_ext;
          qm1_d   = 1'b0;
          mx_d    = m_ext;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_shr;
        qx_d  = qx_shr;
        qm1_d = qx_q[0];
        cnt_d = cnt_q + CntW'(1);
        // cnt_q counts completed steps; step N is the (N+1)-th and last
        if (cnt_q == CntW'(N)) begin
          state_d   = StDone;
          product_d = full_shr[2*N-1:0];
          done_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      qx_q      <= '0;
      qm1_q     <= 1'b0;
      mx_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      qx_q      <= qx_d;
      qm1_q     <= qm1_d;
      mx_q      <= mx_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign ready   = (state_q == StDone);
  assign busy    = (state_q == StRun);
  assign done    = done_q;

endmodule
